sipo_capture_sched: RTL and testbench

- Scheduler that shares one WIDTH-bit serial-in/parallel-out capture register between N_REQ serial requesters.
- Grants one lane at a time using round-robin. Captures WIDTH bits from the granted lane, one bit per clock, into bit index 0..WIDTH-1 (LSB first).
- Presents the completed word on a valid/ready output port.
- Sits between serial-bit sources and any word-wide consumer. Replaces free-running capture that has no framing.

---
 rtl/sipo_capture_sched_pkg.sv | 13 +
 rtl/sipo_capture_sched_rr_pick.sv | 32 +++
 rtl/sipo_capture_sched.sv | 135 +++++++++++++
 tb/tb_sipo_capture_sched.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/sipo_capture_sched_pkg.sv
// Shared types and default sizing for the serial capture scheduler.
package sipo_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 8;
  localparam int N_REQ_DEF = 2;

endpackage

// File: rtl/sipo_capture_sched_rr_pick.sv
// Combinational round-robin selector: first requester at or after ptr,
// wrapping modulo N_REQ. Produces a one-hot grant and its encoded index.
module rr_pick #(
  parameter  int N_REQ = 2,
  localparam int SRC_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SRC_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [SRC_W-1:0] idx
);

  logic             found;
  logic [SRC_W-1:0] cand;

  // Scan lanes starting at the pointer; the first requester wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = SRC_W'((int'(ptr) + i) % N_REQ);
      if (!found && req[cand]) begin
        gnt[cand] = 1'b1;
        idx       = cand;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sipo_capture_sched.sv
// Shares one serial-in/parallel-out capture register between N_REQ serial
// lanes. Grants lanes round-robin, captures WIDTH bits LSB first from the
// granted lane and holds the finished word on a valid/ready port.
module sipo_capture_sched
  import sipo_capture_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  parameter  int N_REQ = N_REQ_DEF,
  localparam int SRC_W = $clog2(N_REQ)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_REQ-1:0] i_req,
  input  logic [N_REQ-1:0] i_bit,
  output logic [N_REQ-1:0] o_gnt,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_data,
  output logic [SRC_W-1:0] o_src,
  output logic             o_valid,
  input  logic             i_ready
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [SRC_W-1:0] ptr;
  logic [SRC_W-1:0] gnt_idx;
  logic [SRC_W-1:0] ptr_inc;
  logic [N_REQ-1:0] pick_gnt;
  logic [SRC_W-1:0] pick_idx;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] word_nxt;
  logic             cur_bit;
  logic             cur_req;
  logic             start, abort, done, accept;

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req (i_req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  assign cur_bit = i_bit[gnt_idx];
  assign cur_req = i_req[gnt_idx];
  assign o_busy  = (state != IDLE);
  assign ptr_inc = (gnt_idx == SRC_W'(N_REQ - 1)) ? '0 : gnt_idx + SRC_W'(1);

  // Capture word as it will look after this edge's bit is inserted.
  always_comb begin
    word_nxt      = shreg;
    word_nxt[cnt] = cur_bit;
  end

  // Next-state decode; a dropped request outranks word completion.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    abort     = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (|i_req) begin
          start     = 1'b1;
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        if (!cur_req) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          done      = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (o_valid && i_ready) begin
          accept    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Grant, counter, pointer and output word registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_gnt   <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_src   <= '0;
      cnt     <= '0;
      ptr     <= '0;
      gnt_idx <= '0;
    end else begin
      if (start) begin
        o_gnt   <= pick_gnt;
        gnt_idx <= pick_idx;
        cnt     <= '0;
      end
      if (state == CAPTURE && !abort && !done) cnt <= cnt + CNT_W'(1);
      if (abort) begin
        o_gnt <= '0;
        cnt   <= '0;
        ptr   <= ptr_inc;
      end
      if (done) begin
        o_gnt   <= '0;
        o_valid <= 1'b1;
        o_data  <= word_nxt;
        o_src   <= gnt_idx;
        ptr     <= ptr_inc;
        cnt     <= '0;
      end
      if (accept) o_valid <= 1'b0;
    end
  end

  // Shift register is pure data: every bit is rewritten before it is used.
  always_ff @(posedge i_clk) begin
    if (state == CAPTURE) shreg <= word_nxt;
  end

endmodule

// File: tb/tb_sipo_capture_sched.sv
// Directed bench for sipo_capture_sched (WIDTH=8, N_REQ=2).
module tb_sipo_capture_sched;

  logic       i_clk;
  logic       i_rst;
  logic [1:0] i_req;
  logic [1:0] i_bit;
  logic [1:0] o_gnt;
  logic       o_busy;
  logic [7:0] o_data;
  logic [0:0] o_src;
  logic       o_valid;
  logic       i_ready;

  int checks   = 0;
  int failures = 0;

  sipo_capture_sched #(.WIDTH(8), .N_REQ(2)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_req   (i_req),
    .i_bit   (i_bit),
    .o_gnt   (o_gnt),
    .o_busy  (o_busy),
    .o_data  (o_data),
    .o_src   (o_src),
    .o_valid (o_valid),
    .i_ready (i_ready)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_req = 2'b00; i_bit = 2'b00; i_ready = 1'b0;
    tick(); tick();
    i_rst = 1'b0;
  endtask

  // Drives one word LSB first on the granted lane; counts cycles the grant was seen.
  task automatic send_word(input int lane, input logic [7:0] w, output int gnt_hits);
    logic [1:0] oh;
    oh = 2'b00;
    oh[lane] = 1'b1;
    gnt_hits = 0;
    for (int k = 0; k < 8; k++) begin
      if (o_gnt === oh) gnt_hits++;
      i_bit = 2'b00;
      i_bit[lane] = w[k];
      tick();
    end
    i_bit = 2'b00;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_req = 2'b11; i_bit = 2'b00; i_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (o_gnt !== 2'b00) begin failures++; $display("FAIL rst_gnt got=%b exp=00", o_gnt); end
      checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", o_valid); end
      checks++; if (o_data !== 8'h00) begin failures++; $display("FAIL rst_data got=%h exp=00", o_data); end
      checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", o_busy); end
      checks++; if (o_src !== 1'b0) begin failures++; $display("FAIL rst_src got=%b exp=0", o_src); end
    end
    i_rst = 1'b0;
    tick();
    checks++; if (o_gnt !== 2'b01) begin failures++; $display("FAIL rst_first_gnt got=%b exp=01", o_gnt); end
  endtask

  task automatic test_single_capture();
    int n;
    do_reset();
    i_req = 2'b01;
    tick();
    checks++; if (o_gnt !== 2'b01) begin failures++; $display("FAIL single_gnt got=%b exp=01", o_gnt); end
    checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", o_busy); end
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%b exp=0", o_valid); end
    send_word(0, 8'hA5, n);
    checks++; if (n !== 8) begin failures++; $display("FAIL single_gnt_cycles got=%0d exp=8", n); end
    checks++; if (o_gnt !== 2'b00) begin failures++; $display("FAIL single_gnt_off got=%b exp=00", o_gnt); end
    checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", o_valid); end
    checks++; if (o_data !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", o_data); end
    checks++; if (o_src !== 1'b0) begin failures++; $display("FAIL single_src got=%b exp=0", o_src); end
    i_req = 2'b00;
    tick();
    checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL single_hold_valid got=%b exp=1", o_valid); end
    i_ready = 1'b1;
    tick();
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL single_accept_valid got=%b exp=0", o_valid); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL single_idle_busy got=%b exp=0", o_busy); end
    i_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    int n;
    do_reset();
    i_req = 2'b11; i_ready = 1'b1;
    tick();
    checks++; if (o_gnt !== 2'b01) begin failures++; $display("FAIL rr_first got=%b exp=01", o_gnt); end
    send_word(0, 8'h5A, n);
    checks++; if (o_data !== 8'h5A) begin failures++; $display("FAIL rr_data0 got=%h exp=5a", o_data); end
    tick();
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL rr_accept0 got=%b exp=0", o_valid); end
    checks++; if (o_gnt !== 2'b00) begin failures++; $display("FAIL rr_bubble0 got=%b exp=00", o_gnt); end
    tick();
    checks++; if (o_gnt !== 2'b10) begin failures++; $display("FAIL rr_second got=%b exp=10", o_gnt); end
    send_word(1, 8'h3C, n);
    checks++; if (n !== 8) begin failures++; $display("FAIL rr_gnt_cycles1 got=%0d exp=8", n); end
    checks++; if (o_data !== 8'h3C) begin failures++; $display("FAIL rr_data1 got=%h exp=3c", o_data); end
    checks++; if (o_src !== 1'b1) begin failures++; $display("FAIL rr_src1 got=%b exp=1", o_src); end
    tick();
    checks++; if (o_gnt !== 2'b00) begin failures++; $display("FAIL rr_bubble1 got=%b exp=00", o_gnt); end
    tick();
    checks++; if (o_gnt !== 2'b01) begin failures++; $display("FAIL rr_third got=%b exp=01", o_gnt); end
    i_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    i_req = 2'b01; i_ready = 1'b0;
    tick();
    send_word(0, 8'hFF, n);
    i_req = 2'b10;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL bp_valid c=%0d got=%b exp=1", c, o_valid); end
      checks++; if (o_data !== 8'hFF) begin failures++; $display("FAIL bp_data c=%0d got=%h exp=ff", c, o_data); end
      checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL bp_busy c=%0d got=%b exp=1", c, o_busy); end
      checks++; if (o_gnt !== 2'b00) begin failures++; $display("FAIL bp_gnt c=%0d got=%b exp=00", c, o_gnt); end
    end
    i_ready = 1'b1;
    tick();
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL bp_release got=%b exp=0", o_valid); end
    checks++; if (o_gnt !== 2'b00) begin failures++; $display("FAIL bp_bubble got=%b exp=00", o_gnt); end
    i_ready = 1'b0;
    tick();
    checks++; if (o_gnt !== 2'b10) begin failures++; $display("FAIL bp_next_gnt got=%b exp=10", o_gnt); end
  endtask

  task automatic test_abort();
    int n;
    do_reset();
    i_req = 2'b01; i_ready = 1'b1;
    tick();
    send_word(0, 8'h96, n);
    checks++; if (o_data !== 8'h96) begin failures++; $display("FAIL ab_prev_data got=%h exp=96", o_data); end
    tick();
    tick();
    checks++; if (o_gnt !== 2'b01) begin failures++; $display("FAIL ab_regrant got=%b exp=01", o_gnt); end
    for (int k = 0; k < 3; k++) begin
      i_bit = 2'b01;
      tick();
    end
    checks++; if (o_gnt !== 2'b01) begin failures++; $display("FAIL ab_mid_gnt got=%b exp=01", o_gnt); end
    i_req = 2'b10;
    tick();
    checks++; if (o_gnt !== 2'b00) begin failures++; $display("FAIL ab_gnt got=%b exp=00", o_gnt); end
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL ab_valid got=%b exp=0", o_valid); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL ab_busy got=%b exp=0", o_busy); end
    checks++; if (o_data !== 8'h96) begin failures++; $display("FAIL ab_data got=%h exp=96", o_data); end
    i_req = 2'b11;
    tick();
    checks++; if (o_gnt !== 2'b10) begin failures++; $display("FAIL ab_next_gnt got=%b exp=10", o_gnt); end
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL ab_no_valid got=%b exp=0", o_valid); end
    i_bit = 2'b00; i_ready = 1'b0;
  endtask

  task automatic test_reset_mid_capture();
    int n;
    do_reset();
    i_req = 2'b11; i_ready = 1'b1;
    tick();
    send_word(0, 8'h11, n);
    checks++; if (o_data !== 8'h11) begin failures++; $display("FAIL rmc_data got=%h exp=11", o_data); end
    tick();
    tick();
    checks++; if (o_gnt !== 2'b10) begin failures++; $display("FAIL rmc_lane1 got=%b exp=10", o_gnt); end
    for (int k = 0; k < 5; k++) begin
      i_bit = 2'b10;
      tick();
    end
    i_rst = 1'b1;
    tick();
    checks++; if (o_gnt !== 2'b00) begin failures++; $display("FAIL rmc_gnt got=%b exp=00", o_gnt); end
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL rmc_valid got=%b exp=0", o_valid); end
    checks++; if (o_data !== 8'h00) begin failures++; $display("FAIL rmc_data_rst got=%h exp=00", o_data); end
    checks++; if (o_src !== 1'b0) begin failures++; $display("FAIL rmc_src got=%b exp=0", o_src); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL rmc_busy got=%b exp=0", o_busy); end
    i_rst = 1'b0;
    tick();
    checks++; if (o_gnt !== 2'b01) begin failures++; $display("FAIL rmc_first_gnt got=%b exp=01", o_gnt); end
    i_bit = 2'b00; i_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_capture();
    test_round_robin();
    test_backpressure();
    test_abort();
    test_reset_mid_capture();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
